tick_ctrl: RTL and testbench
============================

Name: tick_ctrl

Overview:
Run-control and prescaler stage that sits directly upstream of the BCD digit counter chain in the trainer timer. It converts operator start/pause/clear requests into a one-cycle-wide enable (tick) at a fixed divided rate. It drives the digit stage's active-low clear and consumes the digit stage's borrow pulse to detect timeout. It reports running/done status to the display and UI logic.

Parameters:
DIV, 50000000, clk cycles per tick (1 Hz at 50 MHz); legal range 2..2^CNT_W
CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W >= DIV

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  start/resume request, level, already synchronised to clk
pause  input  1  pause/resume toggle request, level, already synchronised
clear  input  1  abort/clear request, level, already synchronised
borrow_in  input  1  one-cycle borrow pulse from the most-significant digit stage
tick  output  1  one-cycle enable pulse to the digit stage (its en input)
dig_rst_n  output  1  active-low clear to the digit stage
running  output  1  high while in RUN
done  output  1  high while in DONE

Behaviour:
- All outputs are registered. All state changes occur on the rising edge of clk.
- Edge detection: start_e = start & ~start_q, and likewise for pause and clear. The start_q, pause_q and clear_q registers reset to 1, so a button held through reset produces no edge.
- Reset (rst=1 at a clock edge) sets: state=IDLE, presc=0, tick=0, dig_rst_n=0, running=0, done=0. Reset mid-operation aborts immediately with no further tick.
- States: IDLE, ARM, RUN, PAUSE, DONE.
- IDLE:
  - dig_rst_n=0 (digit held cleared); tick=0.
  - start_e -> ARM.
- ARM (exactly one cycle):
  - dig_rst_n=1, presc=0.
  - Unconditionally -> RUN.
  - This gives the digit stage its init cycle before any tick.
- RUN:
  - running=1.
  - presc increments each cycle. When presc==DIV-1: presc<=0 and tick<=1 for one cycle. Otherwise tick<=0.
  - The first tick is high in the cycle DIV cycles after RUN is entered; later ticks are spaced exactly DIV cycles apart.
- RUN to PAUSE:
  - pause_e -> PAUSE, with presc held and no tick issued in that cycle. A coincident terminal count is deferred, not lost.
- PAUSE:
  - running=0; presc frozen; tick=0.
  - start_e or pause_e -> RUN, resuming from the held presc.
- Timeout:
  - borrow_in=1 in RUN or PAUSE -> DONE, with tick forced to 0 that cycle.
- DONE:
  - done=1, running=0, tick=0, dig_rst_n=1 (digit shows 0).
  - start_e -> ARM (restart). borrow_in is ignored.
- Priority, highest first: rst > clear_e > borrow_in > pause_e > start_e > terminal-count tick.
- clear_e from any state -> IDLE; dig_rst_n drops to 0 in the next cycle; presc=0.
- Events with no meaning in a state are ignored: start_e in RUN, pause_e in IDLE/ARM/DONE, borrow_in in IDLE/ARM/DONE.
- presc never exceeds DIV-1 and never wraps through 2^CNT_W.

Test Plan:
1. DIV=4. Reset, then start pulse -> ARM for 1 cycle, then RUN. tick is high 4 cycles after RUN entry and every 4 cycles after that. dig_rst_n goes 0 -> 1 at ARM.
2. DIV=4. In RUN, pause pulse at presc=2 -> no ticks for 20 cycles. Second pause pulse -> next tick exactly 2 cycles after resume (presc=2 preserved).
3. DIV=4. Pause edge in the same cycle presc==3 -> no tick that cycle, state=PAUSE. On resume, the tick arrives on the first RUN cycle that reaches terminal count.
4. DIV=4. Assert borrow_in for 1 cycle in RUN, coincident with terminal count -> tick=0, done=1 and running=0 next cycle. A later start pulse -> ARM -> RUN, with done=0.
5. clear asserted in RUN, PAUSE and DONE -> next cycle state=IDLE, dig_rst_n=0, tick=0, running=0, done=0. clear and borrow_in together -> IDLE (clear wins).
6. Hold start high through reset release -> stays in IDLE (no edge). Assert rst mid-RUN at presc=1 -> all outputs at reset values the next cycle, with no tick issued.

Source files
------------

// File: rtl/tick_ctrl.sv
// rtl/tick_ctrl.sv - run-control FSM and tick prescaler feeding the BCD digit chain
module tick_ctrl #(
    parameter int DIV   = 50000000,
    parameter int CNT_W = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pause,
    input  logic clear,
    input  logic borrow_in,
    output logic tick,
    output logic dig_rst_n,
    output logic running,
    output logic done
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, PAUSE, DONE} state_t;

    localparam logic [CNT_W-1:0] TC = CNT_W'(DIV - 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   presc, presc_d;
    logic               tick_d;
    logic               start_q, pause_q, clear_q;
    logic               start_e, pause_e, clear_e;

    assign start_e = start & ~start_q;
    assign pause_e = pause & ~pause_q;
    assign clear_e = clear & ~clear_q;

    always_comb begin
        state_d = state;
        presc_d = presc;
        tick_d  = 1'b0;
        unique case (state)
            IDLE: begin
                presc_d = '0;
                if (start_e) state_d = ARM;
            end
            ARM: begin
                presc_d = '0;
                state_d = RUN;
            end
            RUN: begin
                // pausing on terminal count holds presc at TC so the tick follows resume
                if (borrow_in) begin
                    state_d = DONE;
                end else if (pause_e) begin
                    state_d = PAUSE;
                end else if (presc == TC) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc + CNT_W'(1);
                end
            end
            PAUSE: begin
                if (borrow_in)                state_d = DONE;
                else if (pause_e || start_e)  state_d = RUN;
            end
            DONE: begin
                if (start_e) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
        if (clear_e) begin
            state_d = IDLE;
            presc_d = '0;
            tick_d  = 1'b0;
        end
    end

    // Status outputs are registered decodes of the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            tick      <= 1'b0;
            dig_rst_n <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            start_q   <= 1'b1;
            pause_q   <= 1'b1;
            clear_q   <= 1'b1;
        end else begin
            state     <= state_d;
            presc     <= presc_d;
            tick      <= tick_d;
            dig_rst_n <= (state_d != IDLE);
            running   <= (state_d == RUN);
            done      <= (state_d == DONE);
            start_q   <= start;
            pause_q   <= pause;
            clear_q   <= clear;
        end
    end

endmodule

// File: tb/tb_tick_ctrl.sv
// tb/tb_tick_ctrl.sv - scoreboard bench for tick_ctrl with DIV=4
module tb_tick_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic clear = 1'b0;
    logic borrow_in = 1'b0;
    logic tick, dig_rst_n, running, done;

    always #5 clk = ~clk;

    tick_ctrl #(.DIV(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .borrow_in (borrow_in),
        .tick      (tick),
        .dig_rst_n (dig_rst_n),
        .running   (running),
        .done      (done)
    );

    // expected output vector: {tick, dig_rst_n, running, done}
    localparam logic [3:0] O_IDLE  = 4'b0000;
    localparam logic [3:0] O_ARM   = 4'b0100;
    localparam logic [3:0] O_RUN   = 4'b0110;
    localparam logic [3:0] O_TICK  = 4'b1110;
    localparam logic [3:0] O_PAUSE = 4'b0100;
    localparam logic [3:0] O_DONE  = 4'b0101;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (tick,dig_rst_n,running,done)", tag, got, exp);
    endtask

    // drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic cyc(input logic s, input logic p, input logic c, input logic b,
                       input logic r, input logic [3:0] e, input string tag);
        sb_t it;
        @(negedge clk);
        start = s; pause = p; clear = c; borrow_in = b; rst = r;
        it.tag = tag;
        it.exp = e;
        sb.push_back(it);
    endtask

    task automatic quiet(input int n, input logic [3:0] e, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, e, tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            sb_t it;
            it = sb.pop_front();
            check_eq(it.tag, {tick, dig_rst_n, running, done}, it.exp);
        end
    end

    initial begin
        // reset with start held high, then release: no edge, stay idle
        cyc(1, 0, 0, 0, 1, O_IDLE, "reset");
        cyc(1, 0, 0, 0, 0, O_IDLE, "start_held_thru_rst");
        cyc(0, 0, 0, 0, 0, O_IDLE, "idle");
        // start: one ARM cycle, RUN, ticks every 4 cycles
        cyc(1, 0, 0, 0, 0, O_ARM, "arm");
        cyc(0, 0, 0, 0, 0, O_RUN, "run_entry");
        quiet(3, O_RUN, "run_count");
        quiet(1, O_TICK, "first_tick");
        for (int k = 0; k < 2; k++) begin
            quiet(3, O_RUN, "run_gap");
            quiet(1, O_TICK, "periodic_tick");
        end
        // pause at presc=2, hold 20 cycles, resume: tick after 2 cycles
        quiet(2, O_RUN, "run_to_2");
        cyc(0, 1, 0, 0, 0, O_PAUSE, "pause_at_2");
        quiet(19, O_PAUSE, "paused");
        cyc(0, 1, 0, 0, 0, O_RUN, "resume_pause");
        quiet(1, O_RUN, "resume_count");
        quiet(1, O_TICK, "tick_after_resume");
        // start in RUN is ignored
        cyc(1, 0, 0, 0, 0, O_RUN, "start_in_run");
        quiet(2, O_RUN, "run_gap2");
        quiet(1, O_TICK, "tick_after_start_ign");
        // pause coincident with terminal count defers the tick
        quiet(3, O_RUN, "run_to_tc");
        cyc(0, 1, 0, 0, 0, O_PAUSE, "pause_at_tc");
        quiet(2, O_PAUSE, "paused_tc");
        cyc(1, 0, 0, 0, 0, O_RUN, "resume_start");
        quiet(1, O_TICK, "deferred_tick");
        // borrow coincident with terminal count -> DONE, no tick
        quiet(3, O_RUN, "run_to_tc2");
        cyc(0, 0, 0, 1, 0, O_DONE, "borrow_at_tc");
        cyc(0, 0, 0, 1, 0, O_DONE, "borrow_in_done");
        cyc(0, 1, 0, 0, 0, O_DONE, "pause_in_done");
        cyc(1, 0, 0, 0, 0, O_ARM, "restart_arm");
        cyc(0, 0, 0, 0, 0, O_RUN, "restart_run");
        quiet(3, O_RUN, "restart_count");
        quiet(1, O_TICK, "restart_tick");
        // clear from RUN, PAUSE, DONE; clear beats borrow
        quiet(1, O_RUN, "pre_clear");
        cyc(0, 0, 1, 0, 0, O_IDLE, "clear_run");
        cyc(0, 0, 1, 0, 0, O_IDLE, "clear_held");
        cyc(0, 1, 0, 0, 0, O_IDLE, "pause_in_idle");
        cyc(1, 0, 0, 0, 0, O_ARM, "arm2");
        cyc(0, 0, 0, 0, 0, O_RUN, "run2");
        cyc(0, 1, 0, 0, 0, O_PAUSE, "pause2");
        cyc(0, 0, 1, 0, 0, O_IDLE, "clear_pause");
        cyc(1, 0, 0, 0, 0, O_ARM, "arm3");
        quiet(2, O_RUN, "run3");
        cyc(0, 0, 0, 1, 0, O_DONE, "borrow_run");
        cyc(0, 0, 1, 0, 0, O_IDLE, "clear_done");
        cyc(1, 0, 0, 0, 0, O_ARM, "arm4");
        cyc(0, 0, 0, 0, 0, O_RUN, "run4");
        cyc(0, 0, 1, 1, 0, O_IDLE, "clear_vs_borrow");
        // reset mid-RUN at presc=1: no tick afterwards
        cyc(1, 0, 0, 0, 0, O_ARM, "arm5");
        quiet(2, O_RUN, "run5");
        cyc(0, 0, 0, 0, 1, O_IDLE, "rst_mid_run");
        quiet(5, O_IDLE, "post_rst");

        repeat (2) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
